// File: rtl/bme280_sequencer.sv
// bme280_sequencer: configures a BME280 after reset through a single-byte SPI
// engine, then runs forced-mode measurements (trigger or periodic timer),
// polls the status register until the conversion finishes, reads the eight
// raw data bytes and publishes assembled pressure/temperature/humidity words.
module bme280_sequencer #(
   parameter int unsigned SAMPLE_PERIOD = 50_000_000,
   parameter int unsigned POLL_MAX      = 255,
   parameter logic [7:0]  CTRL_HUM_VAL  = 8'h01,
   parameter logic [7:0]  CTRL_MEAS_VAL = 8'h25,
   parameter logic [7:0]  CONFIG_VAL    = 8'h00
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        trigger,
   output logic        spi_req,
   output logic        spi_rw,
   output logic [6:0]  spi_addr,
   output logic [7:0]  spi_wdata,
   input  logic        spi_done,
   input  logic [7:0]  spi_rdata,
   output logic [19:0] press_raw,
   output logic [19:0] temp_raw,
   output logic [15:0] hum_raw,
   output logic        data_valid,
   output logic        busy,
   output logic        error
);

   localparam int TIMER_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
   localparam int POLL_W  = $clog2(POLL_MAX + 1);
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(SAMPLE_PERIOD - 1);
   localparam logic [POLL_W-1:0]  POLL_LAST  = POLL_W'(POLL_MAX);

   typedef enum logic [2:0] {
      ST_INIT_HUM = 3'd0,
      ST_INIT_CFG = 3'd1,
      ST_IDLE     = 3'd2,
      ST_WR_MEAS  = 3'd3,
      ST_POLL     = 3'd4,
      ST_READ     = 3'd5,
      ST_PUBLISH  = 3'd6
   } state_t;

   state_t              state_q, state_d;
   logic                spi_req_q, spi_req_d;
   logic                spi_rw_q, spi_rw_d;
   logic [6:0]          spi_addr_q, spi_addr_d;
   logic [7:0]          spi_wdata_q, spi_wdata_d;
   logic                pending_q, pending_d;
   logic [TIMER_W-1:0]  timer_q, timer_d;
   logic [POLL_W-1:0]   poll_cnt_q, poll_cnt_d;
   logic [2:0]          byte_idx_q, byte_idx_d;
   logic [7:0]          rx_buf_q [8];
   logic [7:0]          rx_buf_d [8];
   logic [19:0]         press_raw_q, press_raw_d;
   logic [19:0]         temp_raw_q, temp_raw_d;
   logic [15:0]         hum_raw_q, hum_raw_d;
   logic                data_valid_q, data_valid_d;
   logic                busy_q, busy_d;
   logic                error_q, error_d;

   logic                ack_s;
   logic                timer_tc_s;
   logic                pending_clr_s;
   logic                issue_s;
   logic                txn_rw_s;
   logic [6:0]          txn_addr_s;
   logic [7:0]          txn_wdata_s;
   logic [POLL_W-1:0]   poll_inc_s;

   // A completion only counts while a request is outstanding.
   assign ack_s      = spi_req_q & spi_done;
   assign poll_inc_s = poll_cnt_q + POLL_W'(1);

   // Periodic timer: runs while enabled, wraps at the terminal count.
   always_comb begin
      timer_tc_s = 1'b0;
      if (!enable) begin
         timer_d = '0;
      end else if (timer_q == TIMER_LAST) begin
         timer_d    = '0;
         timer_tc_s = 1'b1;
      end else begin
         timer_d = timer_q + TIMER_W'(1);
      end
   end

   // Request latch: a new request wins over the IDLE consume so none is lost.
   always_comb begin
      if (trigger || timer_tc_s) begin
         pending_d = 1'b1;
      end else if (pending_clr_s) begin
         pending_d = 1'b0;
      end else begin
         pending_d = pending_q;
      end
   end

   // Sequencer next-state, transaction fields and result assembly.
   always_comb begin
      state_d       = state_q;
      spi_req_d     = spi_req_q;
      spi_rw_d      = spi_rw_q;
      spi_addr_d    = spi_addr_q;
      spi_wdata_d   = spi_wdata_q;
      poll_cnt_d    = poll_cnt_q;
      byte_idx_d    = byte_idx_q;
      rx_buf_d      = rx_buf_q;
      press_raw_d   = press_raw_q;
      temp_raw_d    = temp_raw_q;
      hum_raw_d     = hum_raw_q;
      data_valid_d  = 1'b0;
      error_d       = error_q;
      pending_clr_s = 1'b0;
      issue_s       = 1'b0;
      txn_rw_s      = 1'b0;
      txn_addr_s    = 7'h00;
      txn_wdata_s   = 8'h00;

      case (state_q)
         ST_INIT_HUM: begin
            issue_s     = 1'b1;
            txn_addr_s  = 7'h72;
            txn_wdata_s = CTRL_HUM_VAL;
            if (ack_s) begin
               state_d = ST_INIT_CFG;
            end else begin
               state_d = ST_INIT_HUM;
            end
         end
         ST_INIT_CFG: begin
            issue_s     = 1'b1;
            txn_addr_s  = 7'h75;
            txn_wdata_s = CONFIG_VAL;
            if (ack_s) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_INIT_CFG;
            end
         end
         ST_IDLE: begin
            if (pending_q) begin
               pending_clr_s = 1'b1;
               poll_cnt_d    = '0;
               state_d       = ST_WR_MEAS;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WR_MEAS: begin
            issue_s     = 1'b1;
            txn_addr_s  = 7'h74;
            txn_wdata_s = CTRL_MEAS_VAL;
            if (ack_s) begin
               state_d = ST_POLL;
            end else begin
               state_d = ST_WR_MEAS;
            end
         end
         ST_POLL: begin
            issue_s    = 1'b1;
            txn_rw_s   = 1'b1;
            txn_addr_s = 7'h73;
            if (ack_s) begin
               poll_cnt_d = poll_inc_s;
               // status[3] is the "measuring" bit
               if (!spi_rdata[3]) begin
                  byte_idx_d = 3'd0;
                  state_d    = ST_READ;
               end else if (poll_inc_s < POLL_LAST) begin
                  state_d = ST_POLL;
               end else begin
                  error_d = 1'b1;
                  state_d = ST_IDLE;
               end
            end else begin
               state_d = ST_POLL;
            end
         end
         ST_READ: begin
            issue_s    = 1'b1;
            txn_rw_s   = 1'b1;
            txn_addr_s = 7'h77 + {4'b0000, byte_idx_q};
            if (ack_s) begin
               rx_buf_d[byte_idx_q] = spi_rdata;
               if (byte_idx_q == 3'd7) begin
                  state_d = ST_PUBLISH;
               end else begin
                  byte_idx_d = byte_idx_q + 3'd1;
                  state_d    = ST_READ;
               end
            end else begin
               state_d = ST_READ;
            end
         end
         ST_PUBLISH: begin
            // xlsb/lsb nibbles carry the low 4 bits of the 20-bit words
            press_raw_d  = {rx_buf_q[0], rx_buf_q[1], rx_buf_q[2][7:4]};
            temp_raw_d   = {rx_buf_q[3], rx_buf_q[4], rx_buf_q[5][7:4]};
            hum_raw_d    = {rx_buf_q[6], rx_buf_q[7]};
            data_valid_d = 1'b1;
            error_d      = 1'b0;
            state_d      = ST_IDLE;
         end
         default: begin
            state_d = ST_INIT_HUM;
         end
      endcase

      // Shared handshake: launch from an idle bus, drop on completion, which
      // guarantees at least one low cycle between transactions.
      if (issue_s && !spi_req_q) begin
         spi_req_d   = 1'b1;
         spi_rw_d    = txn_rw_s;
         spi_addr_d  = txn_addr_s;
         spi_wdata_d = txn_wdata_s;
      end else if (ack_s) begin
         spi_req_d = 1'b0;
      end else begin
         spi_req_d = spi_req_q;
      end

      busy_d = (state_d != ST_IDLE);
   end

   // State and datapath registers; reset drops spi_req at once and reruns INIT.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_INIT_HUM;
         spi_req_q    <= 1'b0;
         spi_rw_q     <= 1'b0;
         spi_addr_q   <= 7'h00;
         spi_wdata_q  <= 8'h00;
         pending_q    <= 1'b0;
         timer_q      <= '0;
         poll_cnt_q   <= '0;
         byte_idx_q   <= 3'd0;
         for (int i = 0; i < 8; i++) begin
            rx_buf_q[i] <= 8'h00;
         end
         press_raw_q  <= 20'h00000;
         temp_raw_q   <= 20'h00000;
         hum_raw_q    <= 16'h0000;
         data_valid_q <= 1'b0;
         busy_q       <= 1'b1;
         error_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         spi_req_q    <= spi_req_d;
         spi_rw_q     <= spi_rw_d;
         spi_addr_q   <= spi_addr_d;
         spi_wdata_q  <= spi_wdata_d;
         pending_q    <= pending_d;
         timer_q      <= timer_d;
         poll_cnt_q   <= poll_cnt_d;
         byte_idx_q   <= byte_idx_d;
         rx_buf_q     <= rx_buf_d;
         press_raw_q  <= press_raw_d;
         temp_raw_q   <= temp_raw_d;
         hum_raw_q    <= hum_raw_d;
         data_valid_q <= data_valid_d;
         busy_q       <= busy_d;
         error_q      <= error_d;
      end
   end

   assign spi_req    = spi_req_q;
   assign spi_rw     = spi_rw_q;
   assign spi_addr   = spi_addr_q;
   assign spi_wdata  = spi_wdata_q;
   assign press_raw  = press_raw_q;
   assign temp_raw   = temp_raw_q;
   assign hum_raw    = hum_raw_q;
   assign data_valid = data_valid_q;
   assign busy       = busy_q;
   assign error      = error_q;

endmodule

// File: tb/tb_bme280_sequencer.sv
// Bench for bme280_sequencer: an SPI engine model answers transactions,
// expected transactions and published words sit in scoreboard queues.
module tb_bme280_sequencer;

   typedef struct packed {
      logic       rw;
      logic [6:0] addr;
      logic [7:0] wdata;
   } txn_t;

   typedef struct {
      int          nbusy;
      logic [7:0]  bst;
      logic [7:0]  rdy;
      logic [63:0] bytes;
      logic [19:0] p;
      logic [19:0] t;
      logic [15:0] h;
   } vec_t;

   logic        clk;
   logic        reset;
   logic        enable;
   logic        trigger;
   logic        spi_req;
   logic        spi_rw;
   logic [6:0]  spi_addr;
   logic [7:0]  spi_wdata;
   logic        spi_done;
   logic [7:0]  spi_rdata;
   logic [19:0] press_raw;
   logic [19:0] temp_raw;
   logic [15:0] hum_raw;
   logic        data_valid;
   logic        busy;
   logic        error;

   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   int          pub_cnt = 0;
   txn_t        exp_txn [$];
   logic [55:0] exp_pub [$];
   logic [7:0]  status_q [$];
   int          meas_starts [$];
   logic [63:0] data_bytes = 64'd0;
   logic        dv_prev = 1'b0;
   logic        eng_active = 1'b0;
   logic        eng_unstable = 1'b0;
   logic [15:0] eng_fields = 16'd0;
   logic [7:0]  eng_resp = 8'd0;
   int          eng_cnt = 0;
   int          eng_delay = 10;
   logic        rand_delay = 1'b0;
   int          low_cnt = 1;
   logic [6:0]  last_addr = 7'd0;

   bme280_sequencer #(
      .SAMPLE_PERIOD(200),
      .POLL_MAX     (4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .trigger   (trigger),
      .spi_req   (spi_req),
      .spi_rw    (spi_rw),
      .spi_addr  (spi_addr),
      .spi_wdata (spi_wdata),
      .spi_done  (spi_done),
      .spi_rdata (spi_rdata),
      .press_raw (press_raw),
      .temp_raw  (temp_raw),
      .hum_raw   (hum_raw),
      .data_valid(data_valid),
      .busy      (busy),
      .error     (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [55:0] words_of(input logic [63:0] b);
      return {b[63:56], b[55:48], b[47:44], b[39:32], b[31:24], b[23:20], b[15:0]};
   endfunction

   // One clock: monitor published words, then run the SPI engine model.
   task automatic tick();
      txn_t        et;
      logic [55:0] ep;
      int          idx;
      @(negedge clk);
      cyc++;
      if (data_valid) begin
         pub_cnt++;
         check("dv_width", 64'(dv_prev), 64'd0);
         total++;
         if (exp_pub.size() == 0) begin
            bad++;
            $display("FAIL unexpected_pub: got %0h/%0h/%0h expected none", press_raw, temp_raw, hum_raw);
         end else begin
            ep = exp_pub.pop_front();
            if ({press_raw, temp_raw, hum_raw} !== ep) begin
               bad++;
               $display("FAIL pub_words: got %0h expected %0h", {press_raw, temp_raw, hum_raw}, ep);
            end
         end
      end
      dv_prev  = data_valid;
      spi_done = 1'b0;
      if (reset) begin
         eng_active = 1'b0;
         low_cnt    = 1;
      end else if (eng_active) begin
         if (!spi_req || ({spi_rw, spi_addr, spi_wdata} != eng_fields)) eng_unstable = 1'b1;
         if (eng_cnt <= 1) begin
            check("txn_stable", 64'(eng_unstable), 64'd0);
            spi_done   = 1'b1;
            spi_rdata  = eng_resp;
            eng_active = 1'b0;
         end else begin
            eng_cnt--;
         end
      end else if (spi_req) begin
         check("req_gap", 64'(low_cnt >= 1), 64'd1);
         eng_fields   = {spi_rw, spi_addr, spi_wdata};
         eng_unstable = 1'b0;
         eng_active   = 1'b1;
         low_cnt      = 0;
         eng_cnt      = rand_delay ? int'($urandom_range(20, 1)) : eng_delay;
         last_addr    = spi_addr;
         if (!spi_rw && spi_addr == 7'h74) meas_starts.push_back(cyc);
         total++;
         if (exp_txn.size() == 0) begin
            bad++;
            $display("FAIL unexpected_txn: got rw=%0d addr=%0h expected none", spi_rw, spi_addr);
         end else begin
            total--;
            et = exp_txn.pop_front();
            check("txn_rw", 64'(spi_rw), 64'(et.rw));
            check("txn_addr", 64'(spi_addr), 64'(et.addr));
            if (!et.rw) check("txn_wdata", 64'(spi_wdata), 64'(et.wdata));
         end
         if (spi_rw && spi_addr == 7'h73) begin
            eng_resp = (status_q.size() > 0) ? status_q.pop_front() : 8'h00;
         end else if (spi_rw && spi_addr >= 7'h77 && spi_addr <= 7'h7E) begin
            idx      = int'(spi_addr) - 'h77;
            eng_resp = data_bytes[63 - 8*idx -: 8];
         end else begin
            eng_resp = 8'h00;
         end
      end else begin
         low_cnt++;
      end
   endtask

   task automatic push_txn(input logic rw, input logic [6:0] a, input logic [7:0] w);
      txn_t t;
      t.rw = rw; t.addr = a; t.wdata = w;
      exp_txn.push_back(t);
   endtask

   // Expected traffic for one measurement: nbusy busy polls, then ready+reads if ok.
   task automatic push_cycle(input int nbusy, input logic [7:0] bst, input logic [7:0] rdy,
                             input logic [63:0] bytes, input logic ok, input logic [55:0] words);
      push_txn(1'b0, 7'h74, 8'h25);
      for (int i = 0; i < nbusy; i++) begin
         push_txn(1'b1, 7'h73, 8'h00);
         status_q.push_back(bst);
      end
      if (ok) begin
         push_txn(1'b1, 7'h73, 8'h00);
         status_q.push_back(rdy);
         for (int i = 0; i < 8; i++) push_txn(1'b1, 7'h77 + 7'(i), 8'h00);
         exp_pub.push_back(words);
      end
      data_bytes = bytes;
   endtask

   task automatic pulse_trigger();
      trigger = 1'b1;
      tick();
      trigger = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n;
      n = 0;
      while (n < budget && !(exp_txn.size() == 0 && exp_pub.size() == 0 && !busy && !spi_req)) begin
         tick();
         n++;
      end
      check(name, 64'(n < budget), 64'd1);
   endtask

   initial begin
      vec_t        vecs [4];
      int          pub0;
      int          n;
      logic [63:0] rb;
      int          nb;

      vecs[0] = '{2, 8'h08, 8'h00, 64'h5012_3080_0040_6677, 20'h50123, 20'h80004, 16'h6677};
      vecs[1] = '{0, 8'h08, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 20'hFFFFF, 20'hFFFFF, 16'hFFFF};
      vecs[2] = '{3, 8'hF8, 8'hF7, 64'h0000_0F12_345A_0001, 20'h00000, 20'h12345, 16'h0001};
      vecs[3] = '{1, 8'h0C, 8'h04, 64'hA55A_C33C_9669_8118, 20'hA55AC, 20'h3C966, 16'h8118};

      reset = 1'b1; enable = 1'b0; trigger = 1'b0; spi_done = 1'b0; spi_rdata = 8'h00;
      repeat (3) tick();
      check("rst_req", 64'(spi_req), 64'd0);
      check("rst_rw", 64'(spi_rw), 64'd0);
      check("rst_addr", 64'(spi_addr), 64'd0);
      check("rst_wdata", 64'(spi_wdata), 64'd0);
      check("rst_words", 64'({press_raw, temp_raw, hum_raw}), 64'd0);
      check("rst_dv", 64'(data_valid), 64'd0);
      check("rst_error", 64'(error), 64'd0);
      check("rst_busy", 64'(busy), 64'd1);

      // Configuration writes after reset
      push_txn(1'b0, 7'h72, 8'h01);
      push_txn(1'b0, 7'h75, 8'h00);
      reset = 1'b0;
      wait_idle("init_idle", 400);
      check("init_busy", 64'(busy), 64'd0);
      check("init_pubs", 64'(pub_cnt), 64'd0);

      // Table of triggered measurements
      for (int v = 0; v < 4; v++) begin
         pub0 = pub_cnt;
         status_q.delete();
         push_cycle(vecs[v].nbusy, vecs[v].bst, vecs[v].rdy, vecs[v].bytes, 1'b1,
                    {vecs[v].p, vecs[v].t, vecs[v].h});
         pulse_trigger();
         wait_idle("vec_idle", 3000);
         check("vec_pubcnt", 64'(pub_cnt - pub0), 64'd1);
         check("vec_press", 64'(press_raw), 64'(vecs[v].p));
         check("vec_temp", 64'(temp_raw), 64'(vecs[v].t));
         check("vec_hum", 64'(hum_raw), 64'(vecs[v].h));
         check("vec_error", 64'(error), 64'd0);
      end

      // Status stuck busy: exactly POLL_MAX polls, then sticky error
      pub0 = pub_cnt;
      status_q.delete();
      push_cycle(4, 8'h08, 8'h00, vecs[0].bytes, 1'b0, 56'd0);
      pulse_trigger();
      wait_idle("timeout_idle", 3000);
      check("timeout_error", 64'(error), 64'd1);
      check("timeout_pubs", 64'(pub_cnt - pub0), 64'd0);
      check("timeout_words", 64'({press_raw, temp_raw, hum_raw}),
            64'({vecs[3].p, vecs[3].t, vecs[3].h}));
      status_q.delete();
      push_cycle(0, 8'h08, 8'h00, vecs[0].bytes, 1'b1, {vecs[0].p, vecs[0].t, vecs[0].h});
      pulse_trigger();
      wait_idle("recover_idle", 3000);
      check("recover_error", 64'(error), 64'd0);

      // Periodic timer
      eng_delay = 2;
      pub0 = pub_cnt;
      status_q.delete();
      meas_starts.delete();
      for (int k = 0; k < 3; k++)
         push_cycle(0, 8'h08, 8'h00, vecs[1].bytes, 1'b1, {vecs[1].p, vecs[1].t, vecs[1].h});
      enable = 1'b1;
      repeat (650) tick();
      enable = 1'b0;
      wait_idle("period_idle", 500);
      check("period_pubs", 64'(pub_cnt - pub0), 64'd3);
      check("period_count", 64'(meas_starts.size()), 64'd3);
      if (meas_starts.size() == 3) begin
         check("period_gap1", 64'(meas_starts[1] - meas_starts[0]), 64'd200);
         check("period_gap2", 64'(meas_starts[2] - meas_starts[1]), 64'd200);
      end

      // Extra triggers while busy collapse into one more cycle
      eng_delay = 10;
      pub0 = pub_cnt;
      status_q.delete();
      push_cycle(0, 8'h08, 8'h00, vecs[3].bytes, 1'b1, {vecs[3].p, vecs[3].t, vecs[3].h});
      push_cycle(0, 8'h08, 8'h00, vecs[3].bytes, 1'b1, {vecs[3].p, vecs[3].t, vecs[3].h});
      pulse_trigger();
      n = 0;
      while (!busy && n < 20) begin tick(); n++; end
      check("busy_seen", 64'(busy), 64'd1);
      pulse_trigger();
      repeat (5) tick();
      pulse_trigger();
      wait_idle("retrig_idle", 3000);
      repeat (50) tick();
      check("retrig_pubs", 64'(pub_cnt - pub0), 64'd2);

      // Trigger coincident with terminal count
      pub0 = pub_cnt;
      status_q.delete();
      push_cycle(0, 8'h08, 8'h00, vecs[2].bytes, 1'b1, {vecs[2].p, vecs[2].t, vecs[2].h});
      enable = 1'b1;
      repeat (199) tick();
      trigger = 1'b1;
      tick();
      trigger = 1'b0;
      enable  = 1'b0;
      wait_idle("coinc_idle", 3000);
      repeat (50) tick();
      check("coinc_pubs", 64'(pub_cnt - pub0), 64'd1);

      // Reset during READ of byte 4, then INIT reruns before a held trigger
      status_q.delete();
      data_bytes = vecs[0].bytes;
      push_txn(1'b0, 7'h74, 8'h25);
      push_txn(1'b1, 7'h73, 8'h00);
      status_q.push_back(8'h00);
      for (int i = 0; i < 5; i++) push_txn(1'b1, 7'h77 + 7'(i), 8'h00);
      last_addr = 7'h00;
      pulse_trigger();
      n = 0;
      while (!(last_addr == 7'h7B && eng_active) && n < 500) begin tick(); n++; end
      check("reach_byte4", 64'(n < 500), 64'd1);
      repeat (3) tick();
      reset = 1'b1;
      #1;
      check("mid_rst_req", 64'(spi_req), 64'd0);
      check("mid_rst_words", 64'({press_raw, temp_raw, hum_raw}), 64'd0);
      check("mid_rst_error", 64'(error), 64'd0);
      check("mid_rst_busy", 64'(busy), 64'd1);
      check("mid_rst_pending_txn", 64'(exp_txn.size()), 64'd0);
      status_q.delete();
      repeat (2) tick();
      pub0 = pub_cnt;
      push_txn(1'b0, 7'h72, 8'h01);
      push_txn(1'b0, 7'h75, 8'h00);
      push_cycle(1, 8'h08, 8'h00, vecs[3].bytes, 1'b1, {vecs[3].p, vecs[3].t, vecs[3].h});
      reset = 1'b0;
      tick();
      pulse_trigger();
      wait_idle("reinit_idle", 3000);
      check("reinit_pubs", 64'(pub_cnt - pub0), 64'd1);

      // Random engine latency and random data
      rand_delay = 1'b1;
      pub0 = pub_cnt;
      for (int c = 0; c < 100; c++) begin
         rb = {$urandom, $urandom};
         nb = int'($urandom_range(3, 0));
         status_q.delete();
         push_cycle(nb, 8'($urandom) | 8'h08, 8'($urandom) & 8'hF7, rb, 1'b1, words_of(rb));
         pulse_trigger();
         wait_idle("rand_idle", 3000);
      end
      check("rand_pubs", 64'(pub_cnt - pub0), 64'd100);
      check("rand_error", 64'(error), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
